// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC and drives the instruction-memory handshake.
// It also computes redirect targets and presents one instruction per cycle to IF/ID.
// Memory wait states, load-use stalls (via a one-entry skid) and squashed in-flight
// requests are absorbed here.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Load_Use,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] id_pc,
  input  logic [15:0] id_imm16,
  input  logic [25:0] id_target,
  input  logic [31:0] jr_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] ins,
  output logic        valid
);

  // RUN: nothing owed; WAIT: request outstanding; SKID: one word parked during a stall;
  // DROP: outstanding request belongs to a squashed path.
  typedef enum logic [1:0] {StRun, StWait, StSkid, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] drop_pc_q, drop_pc_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_ins_q, skid_ins_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] ins_q, ins_d;
  logic        valid_q, valid_d;

  logic        xfer;
  logic        redirect;
  logic [31:0] id_pc_plus4;
  logic [31:0] br_off;
  logic [31:0] target;

  // Request and address: DROP keeps presenting the abandoned address until it completes.
  always_comb begin
    imem_req  = ((state_q == StRun) && !Load_Use) || (state_q == StWait) ||
                (state_q == StDrop);
    imem_addr = (state_q == StDrop) ? drop_pc_q : fetch_pc_q;
    xfer      = imem_req && imem_ready;
  end

  // Redirect target selection; jr beats jump beats branch.
  always_comb begin
    id_pc_plus4 = id_pc + 32'd4;
    br_off      = {{14{id_imm16[15]}}, id_imm16, 2'b00};
    redirect    = (jr || jump || branch_taken) && !Load_Use;
    if (jr) begin
      target = jr_addr;
    end else if (jump) begin
      target = {id_pc_plus4[31:28], id_target, 2'b00};
    end else begin
      target = id_pc_plus4 + br_off;
    end
  end

  // Next-state and presented-instruction logic.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_pc_d  = drop_pc_q;
    skid_pc_d  = skid_pc_q;
    skid_ins_d = skid_ins_q;
    pc_out_d   = pc_out_q;
    ins_d      = ins_q;
    valid_d    = valid_q;

    if (redirect) begin
      fetch_pc_d = target;
      ins_d      = NOP;
      valid_d    = 1'b0;
      skid_pc_d  = '0;
      skid_ins_d = '0;
      if (imem_req && !imem_ready) begin
        // The in-flight request cannot be withdrawn; remember it so it can be drained.
        drop_pc_d = imem_addr;
        state_d   = StDrop;
      end else begin
        state_d = StRun;
      end
    end else if (!Load_Use) begin
      unique case (state_q)
        StRun, StWait: begin
          if (xfer) begin
            pc_out_d   = fetch_pc_q;
            ins_d      = imem_rdata;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = StRun;
          end else begin
            ins_d   = NOP;
            valid_d = 1'b0;
            state_d = StWait;
          end
        end
        StSkid: begin
          pc_out_d = skid_pc_q;
          ins_d    = skid_ins_q;
          valid_d  = 1'b1;
          state_d  = StRun;
        end
        StDrop: begin
          ins_d   = NOP;
          valid_d = 1'b0;
          if (xfer) state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end else begin
      // Stalled: presented outputs hold; only the memory side may make progress.
      unique case (state_q)
        StRun:  state_d = StRun;
        StWait: begin
          if (xfer) begin
            skid_pc_d  = fetch_pc_q;
            skid_ins_d = imem_rdata;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = StSkid;
          end
        end
        StSkid: state_d = StSkid;
        StDrop: begin
          if (xfer) state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      drop_pc_q  <= '0;
      skid_pc_q  <= '0;
      skid_ins_q <= '0;
      pc_out_q   <= '0;
      ins_q      <= NOP;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_pc_q  <= drop_pc_d;
      skid_pc_q  <= skid_pc_d;
      skid_ins_q <= skid_ins_d;
      pc_out_q   <= pc_out_d;
      ins_q      <= ins_d;
      valid_q    <= valid_d;
    end
  end

  assign pc_out = pc_out_q;
  assign ins    = ins_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios with literal expectations,
// then randomized stimulus compared every cycle against a behavioural fetch model.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] NOPW   = 32'h0000_0000;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Load_Use;
  logic        branch_taken;
  logic        jump;
  logic        jr;
  logic [31:0] id_pc;
  logic [15:0] id_imm16;
  logic [25:0] id_target;
  logic [31:0] jr_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] ins;
  logic        valid;

  int n_checks = 0;
  int n_pass   = 0;

  if_fetch_stage #(
    .RESET_PC(RST_PC),
    .NOP     (NOPW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Load_Use    (Load_Use),
    .branch_taken(branch_taken),
    .jump        (jump),
    .jr          (jr),
    .id_pc       (id_pc),
    .id_imm16    (id_imm16),
    .id_target   (id_target),
    .jr_addr     (jr_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .pc_out      (pc_out),
    .ins         (ins),
    .valid       (valid)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address.
  assign imem_rdata = imem_addr ^ KEY;

  // Behavioural model: next address to fetch, whether a request is owed to memory,
  // whether that owed request is a squashed one, and a FIFO of parked words.
  logic [31:0] m_pc, m_sq_addr, m_pc_out, m_ins;
  bit          m_valid, m_owed, m_squash;
  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_pc     = RST_PC;
    m_sq_addr = '0;
    m_owed   = 0;
    m_squash = 0;
    q_pc.delete();
    q_ins.delete();
    m_pc_out = '0;
    m_ins    = NOPW;
    m_valid  = 0;
  endtask

  function automatic bit exp_req();
    return m_owed || (q_pc.size() == 0 && !Load_Use);
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_squash ? m_sq_addr : m_pc;
  endfunction

  // Compare on the falling edge, advance the model, then return 1 time unit past the rise.
  task automatic cycle();
    bit          req, x, redir;
    logic [31:0] addr, rd, tgt;
    int          off;
    @(negedge clk);
    req  = exp_req();
    addr = exp_addr();
    check("imem_req", {31'b0, imem_req}, {31'b0, req});
    check("imem_addr", imem_addr, addr);
    check("pc_out", pc_out, m_pc_out);
    check("ins", ins, m_ins);
    check("valid", {31'b0, valid}, {31'b0, m_valid});
    if (rst_n) begin
      x     = req && imem_ready;
      rd    = addr ^ KEY;
      redir = (jr || jump || branch_taken) && !Load_Use;
      if (redir) begin
        off = $signed(id_imm16);
        if (jr) tgt = jr_addr;
        else if (jump) tgt = ((id_pc + 32'd4) & 32'hF000_0000) | (32'(id_target) << 2);
        else tgt = id_pc + 32'd4 + 32'(off * 4);
        m_squash = req && !imem_ready;
        m_owed   = m_squash;
        if (m_squash) m_sq_addr = addr;
        q_pc.delete();
        q_ins.delete();
        m_ins   = NOPW;
        m_valid = 0;
        m_pc    = tgt;
      end else if (m_squash) begin
        if (!Load_Use) begin
          m_ins   = NOPW;
          m_valid = 0;
        end
        if (x) begin
          m_owed   = 0;
          m_squash = 0;
        end
      end else if (q_pc.size() > 0) begin
        if (!Load_Use) begin
          m_pc_out = q_pc.pop_front();
          m_ins    = q_ins.pop_front();
          m_valid  = 1;
        end
      end else if (!Load_Use) begin
        if (x) begin
          m_pc_out = m_pc;
          m_ins    = rd;
          m_valid  = 1;
          m_pc     = m_pc + 32'd4;
          m_owed   = 0;
        end else begin
          m_ins   = NOPW;
          m_valid = 0;
          m_owed  = 1;
        end
      end else if (m_owed && x) begin
        q_pc.push_back(m_pc);
        q_ins.push_back(rd);
        m_pc   = m_pc + 32'd4;
        m_owed = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    jr           = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    Load_Use   = 1'b0;
    imem_ready = 1'b1;
    id_pc      = '0;
    id_imm16   = '0;
    id_target  = '0;
    jr_addr    = '0;
    clear_redirects();
    model_reset();

    // Reset values.
    repeat (2) cycle();
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_ins", ins, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h1);
    check("rst_addr", imem_addr, 32'h0000_3000);
    rst_n = 1'b1;

    // Zero-wait streaming.
    check("seq_addr0", imem_addr, 32'h0000_3000);
    cycle();
    check("seq_pc0", pc_out, 32'h0000_3000);
    check("seq_ins0", ins, 32'hA5A5_3000);
    check("seq_valid0", {31'b0, valid}, 32'h1);
    check("seq_addr1", imem_addr, 32'h0000_3004);
    cycle();
    check("seq_addr2", imem_addr, 32'h0000_3008);
    cycle();
    check("seq_pc2", pc_out, 32'h0000_3008);

    // Load-use stall for two cycles.
    Load_Use = 1'b1;
    #1;
    check("lu_req", {31'b0, imem_req}, 32'h0);
    cycle();
    cycle();
    check("lu_hold_pc", pc_out, 32'h0000_3008);
    check("lu_hold_ins", ins, 32'hA5A5_3008);
    Load_Use = 1'b0;
    cycle();
    check("lu_resume_pc", pc_out, 32'h0000_300C);
    check("lu_resume_ins", ins, 32'hA5A5_300C);

    // Wait state on 3004 with a stall arriving mid-wait: word parks in the skid.
    do_reset();
    cycle();
    imem_ready = 1'b0;
    cycle();
    Load_Use = 1'b1;
    cycle();
    check("skid_addr", imem_addr, 32'h0000_3004);
    check("skid_req", {31'b0, imem_req}, 32'h1);
    imem_ready = 1'b1;
    cycle();
    check("skid_held_valid", {31'b0, valid}, 32'h0);
    Load_Use = 1'b0;
    cycle();
    check("skid_out_pc", pc_out, 32'h0000_3004);
    check("skid_out_ins", ins, 32'hA5A5_3004);
    cycle();
    check("skid_next_pc", pc_out, 32'h0000_3008);

    // Branches.
    branch_taken = 1'b1;
    id_pc        = 32'h0000_3010;
    id_imm16     = 16'hFFFC;
    cycle();
    clear_redirects();
    check("br_bubble_valid", {31'b0, valid}, 32'h0);
    check("br_bubble_ins", ins, NOPW);
    check("br_addr_neg", imem_addr, 32'h0000_3004);
    cycle();
    check("br_first_pc", pc_out, 32'h0000_3004);
    branch_taken = 1'b1;
    id_imm16     = 16'h7FFF;
    cycle();
    clear_redirects();
    check("br_addr_pos", imem_addr, 32'h0002_3010);

    // jr wins over jump; jump uses the upper nibble of id_pc + 4.
    jr      = 1'b1;
    jump    = 1'b1;
    jr_addr = 32'h0000_4000;
    cycle();
    clear_redirects();
    check("jr_prio_addr", imem_addr, 32'h0000_4000);
    jump      = 1'b1;
    id_pc     = 32'h3FFF_FFFC;
    id_target = 26'h000_0100;
    cycle();
    clear_redirects();
    check("jump_addr", imem_addr, 32'h4000_0400);
    cycle();

    // Redirect while waiting on 3008: squashed request drains before the target fetch.
    jr      = 1'b1;
    jr_addr = 32'h0000_3008;
    cycle();
    clear_redirects();
    imem_ready = 1'b0;
    cycle();
    jr      = 1'b1;
    jr_addr = 32'h0000_5000;
    cycle();
    clear_redirects();
    check("drop_addr0", imem_addr, 32'h0000_3008);
    check("drop_valid0", {31'b0, valid}, 32'h0);
    cycle();
    check("drop_addr1", imem_addr, 32'h0000_3008);
    imem_ready = 1'b1;
    cycle();
    check("drop_valid2", {31'b0, valid}, 32'h0);
    check("drop_tgt_addr", imem_addr, 32'h0000_5000);
    cycle();
    check("drop_tgt_pc", pc_out, 32'h0000_5000);
    check("drop_tgt_ins", ins, 32'hA5A5_5000);

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        Load_Use     = ($urandom_range(0, 3) == 0);
        imem_ready   = ($urandom_range(0, 9) < 6);
        jr           = ($urandom_range(0, 11) == 0);
        jump         = ($urandom_range(0, 11) == 0);
        branch_taken = ($urandom_range(0, 11) == 0);
        id_pc        = $urandom() & 32'hFFFF_FFFC;
        id_imm16     = 16'($urandom());
        id_target    = 26'($urandom());
        jr_addr      = $urandom() & 32'hFFFF_FFFC;
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
